frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Control stage between the UART core's RX frame output and the coprocessor, and between the coprocessor result and the UART core's TX trigger.
- Detects a completed RX frame, snapshots it, and issues it to the coprocessor with a one-cycle din_valid.
- Waits for dout_valid, or for a timeout, then latches the result and pulses tx_trigger to send it back.
- Replaces the tied-off din_valid and the manual TX button path in the top level.

Parameters:
- FRAME_BYTES, 18, bytes per UART frame.
- DBITS, 8, bits per byte.
- TIMEOUT_CYCLES, 1_000_000, maximum cycles spent waiting for dout_valid; must be at least 2.
- TX_GAP_CYCLES, 4096, minimum cycles after tx_trigger before the next frame is accepted, giving the UART TX FIFO time to drain.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_full  in  1  level: the UART RX FIFO holds a complete frame
- rx_frame  in  FRAME_BYTES*DBITS  assembled RX frame; byte 0 in bits [7:0]
- rx_ack  out  1  one-cycle pulse: frame consumed, UART may clear its RX FIFO
- cp_din  out  FRAME_BYTES*DBITS  frame presented to the coprocessor
- cp_din_valid  out  1  one-cycle issue strobe
- cp_dout  in  FRAME_BYTES*DBITS  coprocessor result
- cp_dout_valid  in  1  result strobe; 1 cycle or longer
- tx_frame  out  FRAME_BYTES*DBITS  frame handed to the UART TX path
- tx_trigger  out  1  one-cycle send pulse
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky flag; cleared only by rst
- frame_count  out  16  number of frames sent; wraps modulo 2^16

Behaviour:
- Reset values: all outputs 0, cp_din and tx_frame all-zero, state IDLE, all counters 0. Reset takes effect immediately at any point, including mid-wait. After reset release, a still-high rx_full is NOT taken as a new frame; an edge is required.
- rx_full is registered each cycle as rx_full_q. A start event is rx_full && !rx_full_q.
- IDLE:
  - On a start event: cp_din <= rx_frame; go to ISSUE.
  - Start events in any other state are dropped. They are not queued.
- ISSUE:
  - Lasts exactly 1 cycle. cp_din_valid=1 and rx_ack=1 in this cycle.
  - Timeout counter cleared to 0. Go to WAIT.
  - Latency from the rx_full rising edge (sampled cycle N) to cp_din_valid is 1 cycle: cp_din_valid is high in cycle N+1.
- WAIT:
  - cp_dout_valid is ignored in ISSUE. It is sampled from the first WAIT cycle onward.
  - If cp_dout_valid=1: tx_frame <= cp_dout; go to SEND.
  - Otherwise the timeout counter increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1 with cp_dout_valid still 0: tx_frame <= cp_din (echo of the input frame); timeout_err <= 1; go to SEND.
  - If cp_dout_valid and timeout occur in the same cycle, cp_dout_valid wins: the result is used and timeout_err is not set.
- SEND:
  - Lasts 1 cycle. tx_trigger=1.
  - frame_count <= frame_count+1, wrapping from 0xFFFF to 0.
  - Gap counter cleared. Go to GAP.
- GAP:
  - Gap counter increments each cycle. At TX_GAP_CYCLES-1, go to IDLE.
  - A cp_dout_valid that is still high or arrives late is ignored.
  - rx_full edges are ignored; rx_full_q keeps tracking, so a frame already pending is not re-detected.
- Hold rules:
  - cp_din holds its value from capture until the next capture.
  - tx_frame holds its value from SEND until the next SEND, as the UART TX path reads it after the trigger.
- busy = (state != IDLE), decoded combinationally from the state register.
- Counter widths: $clog2(TIMEOUT_CYCLES) and $clog2(TX_GAP_CYCLES) bits, minimum 1.
- Frame throughput: at most one frame per (3 + wait + TX_GAP_CYCLES) cycles.

Decomposition:
- Shared package frame_pkg:
  - state enum: IDLE, ISSUE, WAIT, SEND, GAP
  - FRAME_W = FRAME_BYTES*DBITS
  - default TIMEOUT_CYCLES and TX_GAP_CYCLES constants
- One natural sub-module: pulse_timer, a loadable up-counter with a terminal-count flag and parameterised width. It is instantiated twice, once for the timeout and once for the gap.
- The FSM and the data registers stay in frame_sequencer.

Test Plan:
- Normal flow:
  - Stimulus: reset, then raise rx_full with rx_frame = bytes 0x01..0x12; drive cp_dout_valid 5 cycles after cp_din_valid with cp_dout = bytes 0xA1..0xB2.
  - Required response: cp_din_valid exactly 1 cycle after the edge; rx_ack on the same cycle; cp_din = 0x01..0x12; tx_trigger 1 cycle after dout_valid; tx_frame = 0xA1..0xB2; frame_count = 1; busy low after TX_GAP_CYCLES.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; cp_dout_valid never asserted.
  - Required response: tx_trigger 16 cycles after WAIT entry; tx_frame equals the input frame; timeout_err=1 and remains 1 through a later normal frame.
- Simultaneous dout_valid and timeout:
  - Stimulus: assert cp_dout_valid on the terminal-count cycle.
  - Required response: tx_frame = cp_dout; timeout_err stays 0.
- Back-pressure:
  - Stimulus: pulse a second rx_full edge during WAIT and another during GAP.
  - Required response: both edges ignored; exactly 1 cp_din_valid; rx_full held high into IDLE produces no new issue.
- Reset mid-operation:
  - Stimulus: assert rst during WAIT, then release it with rx_full still high.
  - Required response: outputs return to 0 immediately; no cp_din_valid until rx_full falls and rises again.
- Counter wrap:
  - Stimulus: run 65536 frames with TX_GAP_CYCLES=2.
  - Required response: frame_count returns to 0.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and default constants for the UART-to-coprocessor frame sequencer.
package frame_pkg;

  localparam int DEF_FRAME_BYTES    = 18;
  localparam int DEF_DBITS          = 8;
  localparam int FRAME_W            = DEF_FRAME_BYTES * DEF_DBITS;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;
  localparam int DEF_TX_GAP_CYCLES  = 4096;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SEND,
    GAP
  } state_e;

  // Counter width for a count that runs 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_sequencer_pulse_timer.sv
// Clearable up-counter whose terminal-count flag goes high when it holds LIMIT-1.
module pulse_timer #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] TC_VALUE = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VALUE);

endmodule

// File: rtl/frame_sequencer.sv
// Takes a completed UART RX frame to the coprocessor, waits for its result (or a
// timeout that echoes the input back), then triggers the UART TX path with it.
module frame_sequencer
  import frame_pkg::*;
#(
  parameter int FRAME_BYTES    = DEF_FRAME_BYTES,
  parameter int DBITS          = DEF_DBITS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TX_GAP_CYCLES  = DEF_TX_GAP_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_full,
  input  logic [FRAME_BYTES*DBITS-1:0] rx_frame,
  output logic                         rx_ack,
  output logic [FRAME_BYTES*DBITS-1:0] cp_din,
  output logic                         cp_din_valid,
  input  logic [FRAME_BYTES*DBITS-1:0] cp_dout,
  input  logic                         cp_dout_valid,
  output logic [FRAME_BYTES*DBITS-1:0] tx_frame,
  output logic                         tx_trigger,
  output logic                         busy,
  output logic                         timeout_err,
  output logic [15:0]                  frame_count
);

  localparam int FW    = FRAME_BYTES * DBITS;
  localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);
  localparam int GAP_W = cnt_width(TX_GAP_CYCLES);

  state_e          state_q, state_d;
  logic            rx_full_q;
  logic [FW-1:0]   cp_din_q, cp_din_d;
  logic [FW-1:0]   tx_frame_q, tx_frame_d;
  logic            err_q, err_d;
  logic [15:0]     count_q, count_d;

  logic            start;
  logic            to_clr, to_en, to_tc;
  logic            gap_clr, gap_en, gap_tc;

  assign start = rx_full && !rx_full_q;

  pulse_timer #(
    .WIDTH(TO_W),
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr_i(to_clr),
    .en_i (to_en),
    .tc_o (to_tc)
  );

  pulse_timer #(
    .WIDTH(GAP_W),
    .LIMIT(TX_GAP_CYCLES)
  ) u_gap (
    .clk  (clk),
    .rst  (rst),
    .clr_i(gap_clr),
    .en_i (gap_en),
    .tc_o (gap_tc)
  );

  always_comb begin
    state_d    = state_q;
    cp_din_d   = cp_din_q;
    tx_frame_d = tx_frame_q;
    err_d      = err_q;
    count_d    = count_q;
    to_clr     = 1'b0;
    to_en      = 1'b0;
    gap_clr    = 1'b0;
    gap_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cp_din_d = rx_frame;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        to_clr  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving on the terminal-count cycle still wins over the timeout.
        if (cp_dout_valid) begin
          tx_frame_d = cp_dout;
          state_d    = SEND;
        end else if (to_tc) begin
          tx_frame_d = cp_din_q;
          err_d      = 1'b1;
          state_d    = SEND;
        end else begin
          to_en = 1'b1;
        end
      end
      SEND: begin
        count_d = count_q + 16'd1;
        gap_clr = 1'b1;
        state_d = GAP;
      end
      GAP: begin
        if (gap_tc) begin
          state_d = IDLE;
        end else begin
          gap_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      // Treat rx_full as already high so a level still present after reset is not a new frame.
      rx_full_q  <= 1'b1;
      cp_din_q   <= '0;
      tx_frame_q <= '0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rx_full_q  <= rx_full;
      cp_din_q   <= cp_din_d;
      tx_frame_q <= tx_frame_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign cp_din_valid = (state_q == ISSUE);
  assign rx_ack       = (state_q == ISSUE);
  assign tx_trigger   = (state_q == SEND);
  assign busy         = (state_q != IDLE);
  assign cp_din       = cp_din_q;
  assign tx_frame     = tx_frame_q;
  assign timeout_err  = err_q;
  assign frame_count  = count_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: directed vector table, hand-written corner
// sequences, randomized traffic against a timeline model, and a frame counter wrap run.
module tb_frame_sequencer;
  import frame_pkg::*;

  localparam int TO   = 16;
  localparam int GAPC = 2;
  localparam int FW   = FRAME_W;
  localparam int NB   = DEF_FRAME_BYTES;
  localparam int INF  = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_full = 1'b0;
  logic          cp_dout_valid = 1'b0;
  logic [FW-1:0] rx_frame = '0;
  logic [FW-1:0] cp_dout = '0;
  logic          rx_ack, cp_din_valid, tx_trigger, busy, timeout_err;
  logic [FW-1:0] cp_din, tx_frame;
  logic [15:0]   frame_count;

  frame_sequencer #(
    .FRAME_BYTES   (DEF_FRAME_BYTES),
    .DBITS         (DEF_DBITS),
    .TIMEOUT_CYCLES(TO),
    .TX_GAP_CYCLES (GAPC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_full      (rx_full),
    .rx_frame     (rx_frame),
    .rx_ack       (rx_ack),
    .cp_din       (cp_din),
    .cp_din_valid (cp_din_valid),
    .cp_dout      (cp_dout),
    .cp_dout_valid(cp_dout_valid),
    .tx_frame     (tx_frame),
    .tx_trigger   (tx_trigger),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b1;

  // Timeline model: cycle numbers of the issue strobe, the send pulse and the return to idle.
  int            m_issue, m_send, m_idle_from;
  bit            m_prev_rx, m_err;
  logic [15:0]   m_count;
  logic [FW-1:0] m_din, m_tx;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_issue     = -1;
    m_send      = -1;
    m_idle_from = 0;
    m_prev_rx   = 1'b1;
    m_err       = 1'b0;
    m_count     = '0;
    m_din       = '0;
    m_tx        = '0;
  endtask

  task automatic model_update();
    if (cyc >= m_idle_from && rx_full && !m_prev_rx) begin
      m_din       = rx_frame;
      m_issue     = cyc + 1;
      m_send      = INF;
      m_idle_from = INF;
    end else if (cyc > m_issue && cyc < m_send) begin
      if (cp_dout_valid) begin
        m_tx   = cp_dout;
        m_send = cyc + 1;
      end else if (cyc - m_issue - 1 == TO - 1) begin
        m_tx   = m_din;
        m_err  = 1'b1;
        m_send = cyc + 1;
      end
    end else if (cyc == m_send) begin
      m_count     = m_count + 16'd1;
      m_idle_from = cyc + 1 + GAPC;
    end
    m_prev_rx = rx_full;
  endtask

  task automatic check_model();
    chk("m_din_valid", FW'(cp_din_valid), FW'(cyc == m_issue));
    chk("m_rx_ack", FW'(rx_ack), FW'(cyc == m_issue));
    chk("m_tx_trigger", FW'(tx_trigger), FW'(cyc == m_send));
    chk("m_busy", FW'(busy), FW'(cyc < m_idle_from));
    chk("m_timeout_err", FW'(timeout_err), FW'(m_err));
    chk("m_frame_count", FW'(frame_count), FW'(m_count));
    chk("m_cp_din", cp_din, m_din);
    chk("m_tx_frame", tx_frame, m_tx);
  endtask

  // One clock cycle: check this cycle's outputs, advance the model, move to the next negedge.
  task automatic tick();
    if (chk_en) check_model();
    if (rst) model_reset();
    else model_update();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_idle(input string name);
    for (int i = 0; i < 200 && cyc < m_idle_from; i++) tick();
    chk(name, FW'(busy), '0);
  endtask

  function automatic logic [FW-1:0] make_frame(input logic [7:0] base);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < NB; i++) f[i*8 +: 8] = base + 8'(i);
    return f;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < NB; i++) f[i*8 +: 8] = 8'($urandom);
    return f;
  endfunction

  typedef struct {
    int         dly;       // cp_dout_valid cycles after cp_din_valid, -1 for never
    int         exp_off;   // tx_trigger cycles after cp_din_valid
    bit         use_dout;  // tx_frame is the result rather than the echoed input
    bit         exp_err;
    logic [7:0] rx_base;
    logic [7:0] dout_base;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #(60_000_000);
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k_issue, k_send, k_idle, n_issue, n_send;
    bit seen_ack;
    logic [FW-1:0] exp_rx, exp_dout, seen_tx, seen_din;

    vecs[0] = '{5, 6, 1'b1, 1'b0, 8'h01, 8'hA1};
    vecs[1] = '{16, 17, 1'b1, 1'b0, 8'h30, 8'hC0};
    vecs[2] = '{1, 2, 1'b1, 1'b0, 8'h50, 8'h70};
    vecs[3] = '{0, 17, 1'b0, 1'b1, 8'h90, 8'hE0};
    vecs[4] = '{-1, 17, 1'b0, 1'b1, 8'h11, 8'h22};
    vecs[5] = '{3, 4, 1'b1, 1'b1, 8'h33, 8'h44};

    model_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", FW'(busy), '0);
    chk("reset_din_valid", FW'(cp_din_valid), '0);
    chk("reset_rx_ack", FW'(rx_ack), '0);
    chk("reset_tx_trigger", FW'(tx_trigger), '0);
    chk("reset_timeout_err", FW'(timeout_err), '0);
    chk("reset_frame_count", FW'(frame_count), '0);
    chk("reset_cp_din", cp_din, '0);
    chk("reset_tx_frame", tx_frame, '0);
    tick();
    rst = 1'b0;
    tick();

    // Directed vector table.
    for (int r = 0; r < 6; r++) begin
      k_issue = -1; k_send = -1; k_idle = -1; n_issue = 0;
      seen_ack = 1'b0; seen_tx = '0; seen_din = '0;
      exp_rx   = make_frame(vecs[r].rx_base);
      exp_dout = make_frame(vecs[r].dout_base);
      rx_full = 1'b0;
      tick();
      rx_frame = exp_rx;
      cp_dout  = exp_dout;
      rx_full  = 1'b1;
      for (int k = 0; k < 60 && k_idle < 0; k++) begin
        cp_dout_valid = (vecs[r].dly >= 0 && k == 1 + vecs[r].dly);
        if (cp_din_valid) begin
          n_issue++; k_issue = k; seen_ack = rx_ack; seen_din = cp_din;
        end
        if (tx_trigger) begin
          k_send = k; seen_tx = tx_frame;
        end
        if (k_send >= 0 && k > k_send && !busy) k_idle = k;
        tick();
      end
      cp_dout_valid = 1'b0;
      chk("vec_issue_latency", FW'(k_issue), FW'(1));
      chk("vec_issue_count", FW'(n_issue), FW'(1));
      chk("vec_rx_ack", FW'(seen_ack), FW'(1));
      chk("vec_cp_din", seen_din, exp_rx);
      chk("vec_send_offset", FW'(k_send - k_issue), FW'(vecs[r].exp_off));
      chk("vec_tx_frame", seen_tx, vecs[r].use_dout ? exp_dout : exp_rx);
      chk("vec_idle_offset", FW'(k_idle - k_send), FW'(GAPC + 1));
      chk("vec_timeout_err", FW'(timeout_err), FW'(vecs[r].exp_err));
      chk("vec_frame_count", FW'(frame_count), FW'(r + 1));
      $display("vec %0d: dly=%0d issue_k=%0d send_k=%0d idle_k=%0d err=%0b count=%0d tx=%h",
               r, vecs[r].dly, k_issue, k_send, k_idle, timeout_err, frame_count, seen_tx);
    end

    // Back-pressure: rx_full edges during WAIT and GAP, then held high into IDLE.
    n_issue = 0; n_send = 0;
    exp_rx = make_frame(8'h60);
    rx_full = 1'b0;
    tick();
    rx_frame = exp_rx;
    cp_dout  = make_frame(8'h80);
    for (int k = 0; k <= 20; k++) begin
      rx_full = !(k == 3 || k == 10);
      cp_dout_valid = (k == 9);
      if (k == 5) rx_frame = make_frame(8'hF0);
      if (cp_din_valid) n_issue++;
      if (tx_trigger) n_send++;
      tick();
    end
    cp_dout_valid = 1'b0;
    chk("bp_issue_count", FW'(n_issue), FW'(1));
    chk("bp_send_count", FW'(n_send), FW'(1));
    chk("bp_busy_end", FW'(busy), '0);
    chk("bp_cp_din", cp_din, exp_rx);
    $display("backpressure: issues=%0d sends=%0d count=%0d", n_issue, n_send, frame_count);

    // Reset while waiting, released with rx_full still high.
    rx_full = 1'b0;
    tick();
    rx_frame = make_frame(8'h07);
    rx_full = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_busy", FW'(busy), '0);
    chk("midrst_timeout_err", FW'(timeout_err), '0);
    chk("midrst_frame_count", FW'(frame_count), '0);
    chk("midrst_tx_frame", tx_frame, '0);
    chk("midrst_cp_din", cp_din, '0);
    tick();
    tick();
    rst = 1'b0;
    n_issue = 0;
    for (int k = 0; k < 8; k++) begin
      if (cp_din_valid) n_issue++;
      tick();
    end
    chk("midrst_no_issue", FW'(n_issue), '0);
    rx_full = 1'b0;
    tick();
    rx_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (cp_din_valid) n_issue++;
      tick();
    end
    chk("midrst_reissue", FW'(n_issue), FW'(1));
    cp_dout_valid = 1'b1;
    run_until_idle("midrst_idle");
    cp_dout_valid = 1'b0;
    $display("reset mid-wait: issues after re-edge=%0d count=%0d", n_issue, frame_count);

    // Randomized traffic checked every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) rx_full = !rx_full;
      rx_frame = rand_frame();
      cp_dout  = rand_frame();
      cp_dout_valid = ($urandom_range(0, 19) == 0);
      tick();
    end
    cp_dout_valid = 1'b0;
    $display("random: frames=%0d timeout_err=%0b", frame_count, timeout_err);

    // Frame counter wrap over 65536 frames.
    rst = 1'b1;
    #1;
    model_reset();
    tick();
    rst = 1'b0;
    rx_full = 1'b0;
    tick();
    chk_en = 1'b0;
    cp_dout_valid = 1'b1;
    n_send = 0;
    for (int f = 0; f < 65536; f++) begin
      rx_full = 1'b1;
      tick();
      rx_full = 1'b0;
      for (int i = 0; i < 20 && cyc < m_idle_from; i++) begin
        if (tx_trigger) n_send++;
        tick();
      end
      if (f == 65534) chk("wrap_count_ffff", FW'(frame_count), FW'(16'hFFFF));
    end
    cp_dout_valid = 1'b0;
    chk_en = 1'b1;
    chk("wrap_send_count", FW'(n_send), FW'(65536));
    chk("wrap_count_zero", FW'(frame_count), '0);
    chk("wrap_busy", FW'(busy), '0);
    $display("wrap: sends=%0d count=%0d", n_send, frame_count);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
